// File: rtl/fp32_accum_pkg.sv
// fp32_accum_pkg: shared widths, exception codes, constants and FSM state type.
// Revision 1.0
`default_nettype none

package fp32_accum_pkg;

   localparam int FP_W = 34;

   localparam logic [1:0] EXN_ZERO   = 2'b00;
   localparam logic [1:0] EXN_NORMAL = 2'b01;
   localparam logic [1:0] EXN_INF    = 2'b10;
   localparam logic [1:0] EXN_NAN    = 2'b11;

   localparam logic [FP_W-1:0] FP_POS_ZERO = 34'h000000000;
   localparam logic [FP_W-1:0] FP_QNAN     = 34'h300000000;

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fp32_add.sv
// fp32_add: combinational adder for the 34-bit exn-tagged FP format, round-to-nearest-even.
// Revision 1.0
`default_nettype none

module fp32_add
   import fp32_accum_pkg::*;
(
   input  logic [FP_W-1:0] i_x,
   input  logic [FP_W-1:0] i_y,
   output logic [FP_W-1:0] o_sum
);

   logic [1:0]  w_xe, w_ye;
   logic        w_xs, w_ys, w_x_ge;
   logic        w_bs, w_ss;
   logic [7:0]  w_bexp, w_sexp, w_beff, w_seff, w_d;
   logic [22:0] w_bfrac, w_sfrac;
   logic [23:0] w_bm, w_sm;
   logic [4:0]  w_dc;
   logic [53:0] w_al;
   logic [26:0] w_ba, w_sa;
   logic [27:0] w_sum28;
   logic [4:0]  w_lz;
   logic [26:0] w_n;
   logic [9:0]  w_e, w_ef;
   logic [23:0] w_m, w_mant;
   logic        w_up;
   logic [24:0] w_mr;
   logic [FP_W-1:0] w_fin;

   assign w_xe   = i_x[33:32];
   assign w_ye   = i_y[33:32];
   assign w_xs   = i_x[31];
   assign w_ys   = i_y[31];
   assign w_x_ge = (i_x[30:0] >= i_y[30:0]);

   assign w_bs    = w_x_ge ? w_xs : w_ys;
   assign w_ss    = w_x_ge ? w_ys : w_xs;
   assign w_bexp  = w_x_ge ? i_x[30:23] : i_y[30:23];
   assign w_sexp  = w_x_ge ? i_y[30:23] : i_x[30:23];
   assign w_bfrac = w_x_ge ? i_x[22:0] : i_y[22:0];
   assign w_sfrac = w_x_ge ? i_y[22:0] : i_x[22:0];

   // Exponent field 0 is subnormal: no hidden bit, effective exponent 1.
   assign w_beff = (w_bexp == 8'd0) ? 8'd1 : w_bexp;
   assign w_seff = (w_sexp == 8'd0) ? 8'd1 : w_sexp;
   assign w_bm   = {(w_bexp != 8'd0), w_bfrac};
   assign w_sm   = {(w_sexp != 8'd0), w_sfrac};
   assign w_d    = w_beff - w_seff;
   assign w_dc   = (w_d > 8'd30) ? 5'd30 : w_d[4:0];

   assign w_al    = {w_sm, 3'b000, 27'b0} >> w_dc;
   assign w_sa    = {w_al[53:28], w_al[27] | (|w_al[26:0])};
   assign w_ba    = {w_bm, 3'b000};
   assign w_sum28 = (w_bs == w_ss) ? ({1'b0, w_ba} + {1'b0, w_sa})
                                   : ({1'b0, w_ba} - {1'b0, w_sa});

   always_comb begin
      w_lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (w_sum28[i]) w_lz = 5'(26 - i);
      end
   end

   // Left shifts stop at the subnormal boundary.
   always_comb begin
      w_n = w_sum28[26:0];
      w_e = {2'b0, w_beff};
      if (w_sum28[27]) begin
         w_n = {w_sum28[27:2], w_sum28[1] | w_sum28[0]};
         w_e = {2'b0, w_beff} + 10'd1;
      end else if ({3'b0, w_lz} < w_beff) begin
         w_n = w_sum28[26:0] << w_lz;
         w_e = {2'b0, w_beff} - {5'b0, w_lz};
      end else begin
         w_n = w_sum28[26:0] << (w_beff - 8'd1);
         w_e = 10'd0;
      end
   end

   assign w_m  = w_n[26:3];
   assign w_up = w_n[2] & ((|w_n[1:0]) | w_m[0]);
   assign w_mr = {1'b0, w_m} + {24'b0, w_up};

   always_comb begin
      w_mant = w_mr[23:0];
      w_ef   = (w_e == 10'd0 && w_mr[23]) ? 10'd1 : w_e;
      if (w_mr[24]) begin
         w_mant = w_mr[24:1];
         w_ef   = w_e + 10'd1;
      end
      if (w_sum28 == 28'd0)
         w_fin = FP_POS_ZERO;
      else if (w_ef >= 10'd255)
         w_fin = {EXN_INF, w_bs, 31'b0};
      else
         w_fin = {EXN_NORMAL, w_bs, w_ef[7:0], w_mant[22:0]};
   end

   always_comb begin
      o_sum = w_fin;
      if (w_xe == EXN_NAN || w_ye == EXN_NAN)
         o_sum = FP_QNAN;
      else if (w_xe == EXN_INF && w_ye == EXN_INF)
         o_sum = (w_xs == w_ys) ? {EXN_INF, w_xs, 31'b0} : FP_QNAN;
      else if (w_xe == EXN_INF)
         o_sum = {EXN_INF, w_xs, 31'b0};
      else if (w_ye == EXN_INF)
         o_sum = {EXN_INF, w_ys, 31'b0};
      else if (w_xe == EXN_ZERO && w_ye == EXN_ZERO)
         o_sum = {EXN_ZERO, w_xs & w_ys, 31'b0};
      else if (w_xe == EXN_ZERO)
         o_sum = i_y;
      else if (w_ye == EXN_ZERO)
         o_sum = i_x;
   end

endmodule

`default_nettype wire

// File: rtl/fp32_accum.sv
// fp32_accum: streaming FP accumulator; sums beats until in_last, then holds the result.
// Revision 1.0
`default_nettype none

module fp32_accum
   import fp32_accum_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_nan
);

   state_t           r_state, w_state_nxt;
   logic [FP_W-1:0]  r_acc, w_sum, r_out_data;
   logic [CNT_W-1:0] r_cnt, w_cnt_inc, r_out_count;
   logic             r_nan_sticky, w_nan_upd, r_out_nan;
   logic             w_accept, w_out_hs;

   fp32_add u_add (
      .i_x   (r_acc),
      .i_y   (in_data),
      .o_sum (w_sum)
   );

   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_DONE);
   assign w_accept  = in_valid & in_ready;
   assign w_out_hs  = out_valid & out_ready;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_nan_upd = r_nan_sticky | (in_data[FP_W-1:FP_W-2] == EXN_NAN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_ACC;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:  if (w_accept && in_last) w_state_nxt = ST_DONE;
         ST_DONE: if (w_out_hs)            w_state_nxt = ST_ACC;
         default: w_state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc        <= FP_POS_ZERO;
         r_cnt        <= '0;
         r_nan_sticky <= 1'b0;
         r_out_data   <= FP_POS_ZERO;
         r_out_count  <= '0;
         r_out_nan    <= 1'b0;
      end else if (w_accept) begin
         r_acc        <= w_sum;
         r_cnt        <= w_cnt_inc;
         r_nan_sticky <= w_nan_upd;
         if (in_last) begin
            r_out_data  <= w_sum;
            r_out_count <= w_cnt_inc;
            r_out_nan   <= w_nan_upd;
         end
      end else if (w_out_hs) begin
         r_acc        <= FP_POS_ZERO;
         r_cnt        <= '0;
         r_nan_sticky <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_count = r_out_count;
   assign out_nan   = r_out_nan;

endmodule

`default_nettype wire

// File: tb/tb_fp32_accum.sv
// tb_fp32_accum: directed literal checks plus randomized streams against a real-arithmetic model.
// Revision 1.0
`default_nettype none

module tb_fp32_accum;

   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [33:0]   in_data = '0;
   logic          in_ready, out_valid, out_nan;
   logic [33:0]   out_data;
   logic [CW-1:0] out_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   fp32_accum #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_nan   (out_nan)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: values as IEEE doubles ----------------
   function automatic real fp_to_real(input logic [33:0] v);
      logic [63:0] b;
      if (v[33:32] == 2'b00) b = {v[31], 63'b0};
      else                   b = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'b0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [33:0] real_to_fp(input real r);
      logic [63:0] b;
      logic [52:0] m53;
      logic [24:0] m;
      logic [28:0] rem;
      int          e;
      b = $realtobits(r);
      if (b[62:0] == 63'b0) return {2'b00, b[63], 31'b0};
      e   = int'(b[62:52]) - 896;
      m53 = {1'b1, b[51:0]};
      m   = {1'b0, m53[52:29]};
      rem = m53[28:0];
      if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      return {2'b01, b[63], e[7:0], m[22:0]};
   endfunction

   bit          m_done, m_isgn, m_nan, m_out_nan;
   int          m_kind;   // 0 finite, 1 infinity, 2 NaN
   int          m_cnt;
   real         m_val;
   logic [33:0] m_out_data;
   logic [CW-1:0] m_out_cnt;

   function automatic logic [33:0] m_encode();
      if (m_kind == 2) return 34'h300000000;
      if (m_kind == 1) return {2'b10, m_isgn, 31'b0};
      return real_to_fp(m_val);
   endfunction

   task automatic m_clear_sum();
      m_kind = 0; m_isgn = 1'b0; m_val = 0.0; m_cnt = 0; m_nan = 1'b0;
   endtask

   task automatic m_beat(input logic [33:0] y);
      logic [1:0] ye;
      ye = y[33:32];
      if (m_kind == 2 || ye == 2'b11) m_kind = 2;
      else if (m_kind == 1) begin
         if (ye == 2'b10 && y[31] != m_isgn) m_kind = 2;
      end else if (ye == 2'b10) begin
         m_kind = 1;
         m_isgn = y[31];
      end else m_val = fp_to_real(real_to_fp(m_val + fp_to_real(y)));
      if (m_cnt < CMAX) m_cnt++;
      if (ye == 2'b11) m_nan = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_done = 1'b0;
         m_clear_sum();
         m_out_data = '0; m_out_cnt = '0; m_out_nan = 1'b0;
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd1);
      end else begin
         check("in_ready", 64'(in_ready), 64'(!m_done));
         check("out_valid", 64'(out_valid), 64'(m_done));
      end
      check("out_data", 64'(out_data), 64'(m_out_data));
      check("out_count", 64'(out_count), 64'(m_out_cnt));
      check("out_nan", 64'(out_nan), 64'(m_out_nan));
      if (!rst) begin
         if (!m_done && in_valid) begin
            m_beat(in_data);
            if (in_last) begin
               m_out_data = m_encode();
               m_out_cnt  = CW'(m_cnt);
               m_out_nan  = m_nan;
               m_done     = 1'b1;
            end
         end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_clear_sum();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input logic [33:0] d, input logic last, output int at);
      bit got;
      got = 1'b0;
      at  = -1;
      in_valid = 1'b1; in_data = d; in_last = last;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
         if (got) at = cyc;
      end
      check("beat_accepted", 64'(got), 64'd1);
   endtask

   task automatic wait_result(input string name, input logic [33:0] ed, input logic [33:0] mask,
                              input int ec, input logic en);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check({name, "_valid"}, 64'(seen), 64'd1);
      check({name, "_data"}, 64'(out_data & mask), 64'(ed & mask));
      check({name, "_count"}, 64'(out_count), 64'(ec));
      check({name, "_nan"}, 64'(out_nan), 64'(en));
      @(posedge clk); #1;
   endtask

   function automatic logic [33:0] rand_op();
      int unsigned sel;
      logic [7:0]  e;
      logic [22:0] f;
      logic        s;
      sel = $urandom % 64;
      e   = 8'(120 + ($urandom % 15));
      f   = 23'($urandom);
      s   = 1'($urandom);
      if (sel < 2)   return {2'b00, s, 31'b0};
      if (sel == 2)  return {2'b11, 32'($urandom)};
      if (sel == 3)  return {2'b10, s, 31'b0};
      return {2'b01, s, e, f};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int t0, ta, tb;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_out_count", 64'(out_count), 64'd0);
      @(posedge clk); #1;

      // 0.5 + 1.0 + 3.0 = 4.5
      out_ready = 1'b1;
      send_beat(34'h13f000000, 1'b0, t0);
      send_beat(34'h13f800000, 1'b0, t0);
      send_beat(34'h140400000, 1'b1, t0);
      in_valid = 1'b0;
      wait_result("sum3", 34'h140900000, '1, 3, 1'b0);

      send_beat(34'h140a00000, 1'b1, t0);
      in_valid = 1'b0;
      wait_result("single", 34'h140a00000, '1, 1, 1'b0);

      // -2.0 + -2.5 = -4.5, then hold under backpressure
      out_ready = 1'b0;
      send_beat(34'h1c0000000, 1'b0, t0);
      send_beat(34'h1c0200000, 1'b1, t0);
      in_valid = 1'b0;
      wait_result("neg", 34'h1c0900000, '1, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = {2'b01, 32'($urandom)}; in_last = 1'($urandom);
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_data", 64'(out_data), 64'h1c0900000);
         check("hold_count", 64'(out_count), 64'd2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;

      send_beat(34'h13f800000, 1'b0, t0);
      send_beat(34'h300000000, 1'b0, t0);
      send_beat(34'h13f800000, 1'b1, t0);
      in_valid = 1'b0;
      wait_result("nan", 34'h300000000, 34'h300000000, 3, 1'b1);

      // partial sum discarded by a mid-cycle reset
      send_beat(34'h140400000, 1'b0, t0);
      in_valid = 1'b0;
      #3 rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      send_beat(34'h13f000000, 1'b1, t0);
      in_valid = 1'b0;
      wait_result("after_rst", 34'h13f000000, '1, 1, 1'b0);

      // back-to-back: 1.0 + 2.0, then 4.0 alone
      send_beat(34'h13f800000, 1'b0, t0);
      send_beat(34'h140000000, 1'b1, ta);
      send_beat(34'h140800000, 1'b1, tb);
      in_valid = 1'b0;
      check("b2b_gap", 64'(tb - ta), 64'd2);
      wait_result("b2b", 34'h140800000, '1, 1, 1'b0);

      for (int c = 0; c < 4000; c++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = rand_op();
         in_last   = ($urandom % 6) == 0;
         out_ready = ($urandom % 3) != 0;
         rst       = (c % 700) == 350;
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
